// File: rtl/mips_fetch_unit_pkg.sv
// rtl/mips_fetch_unit_pkg.sv - shared core constants and fetch state type
// Contents:
//   INSTR_W                - instruction word width
//   DEFAULT_RESET_VECTOR   - first fetch address after reset
//   DEFAULT_HALT_ADDR      - redirect target that ends execution
//   fetch_state_e          - fetch unit run state
package mips_fetch_unit_pkg;

  localparam int unsigned INSTR_W              = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTING = 2'd1,
    ST_HALTED  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - MIPS instruction fetch stage with halt and fault handling
// Ports:
//   clk             in   clock, all state on rising edge
//   reset           in   synchronous active-low reset
//   stall           in   downstream hold, freezes all fetch state
//   redirect_valid  in   control transfer request from decode
//   redirect_target in   byte address of the transfer target
//   instr_address   out  address to instruction RAM (the PC)
//   instr_readdata  in   instruction word for instr_address
//   if_valid        out  if_instr/if_pc hold a live instruction
//   if_pc           out  byte address of if_instr
//   if_instr        out  registered instruction word
//   active          out  core running
//   fetch_fault     out  sticky misaligned-redirect flag
module mips_fetch_unit
  import mips_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic [31:0]        instr_address,
  input  logic [INSTR_W-1:0] instr_readdata,
  output logic               if_valid,
  output logic [31:0]        if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               active,
  output logic               fetch_fault
);

  fetch_state_e       r_state;
  logic [31:0]        r_pc;
  logic               r_if_valid;
  logic [31:0]        r_if_pc;
  logic [INSTR_W-1:0] r_if_instr;
  logic               r_fault;

  logic w_misaligned;
  logic w_halt_hit;

  assign w_misaligned = (redirect_target[1:0] != 2'b00);
  assign w_halt_hit   = (redirect_target == HALT_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_VECTOR;
      r_if_valid <= 1'b0;
      r_if_pc    <= 32'd0;
      r_if_instr <= '0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!stall) begin
            // A misaligned target aborts before the delay slot is captured
            // and wins over the halt-address check.
            if (redirect_valid && w_misaligned) begin
              r_fault    <= 1'b1;
              r_if_valid <= 1'b0;
              r_state    <= ST_HALTED;
            end else begin
              r_if_instr <= instr_readdata;
              r_if_pc    <= r_pc;
              r_if_valid <= 1'b1;
              if (redirect_valid) begin
                r_pc <= redirect_target;
                if (w_halt_hit) begin
                  r_state <= ST_HALTING;
                end
              end else begin
                r_pc <= r_pc + 32'd4;
              end
            end
          end
        end
        ST_HALTING: begin
          // Delay slot already delivered; retire it and stop.
          if (!stall) begin
            r_if_valid <= 1'b0;
            r_state    <= ST_HALTED;
          end
        end
        ST_HALTED: begin
        end
        default: begin
          r_state <= ST_HALTED;
        end
      endcase
    end
  end

  assign instr_address = r_pc;
  assign if_valid      = r_if_valid;
  assign if_pc         = r_if_pc;
  assign if_instr      = r_if_instr;
  assign active        = (r_state != ST_HALTED);
  assign fetch_fault   = r_fault;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - scoreboard bench for mips_fetch_unit
module tb_mips_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        active;
  logic        fetch_fault;

  mips_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .active          (active),
    .fetch_fault     (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction RAM: deterministic content derived from the address.
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign instr_readdata = ram_word(instr_address);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model of the architectural behaviour.
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_fault;
  logic        m_halt_pending;
  logic        m_stopped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Decode consumes the presented instruction on every edge with stall=0.
  always @(negedge clk) begin
    if (reset && if_valid && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual_pc=%h expected=none", if_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc", if_pc, e.pc);
        chk("sb_instr", if_instr, e.instr);
      end
    end
  end

  task automatic check_outputs();
    chk("instr_address", instr_address, m_pc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    chk("active", {31'd0, active}, {31'd0, ~m_stopped});
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
  endtask

  task automatic step(input logic s, input logic rv, input logic [31:0] tgt);
    stall           = s;
    redirect_valid  = rv;
    redirect_target = tgt;
    if (!m_stopped && !m_halt_pending && !s) begin
      if (rv && (tgt % 4 != 0)) begin
        m_fault   = 1'b1;
        m_valid   = 1'b0;
        m_stopped = 1'b1;
      end else begin
        exp_q.push_back('{pc: m_pc, instr: ram_word(m_pc)});
        m_valid = 1'b1;
        if (rv) begin
          m_pc = tgt;
          if (tgt == 32'h0) m_halt_pending = 1'b1;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end else if (m_halt_pending && !s) begin
      m_valid        = 1'b0;
      m_halt_pending = 1'b0;
      m_stopped      = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int cycles);
    reset          = 1'b0;
    stall          = $urandom_range(0, 1);
    redirect_valid = $urandom_range(0, 1);
    redirect_target = 32'h0;
    exp_q.delete();
    m_pc           = 32'hBFC0_0000;
    m_valid        = 1'b0;
    m_fault        = 1'b0;
    m_halt_pending = 1'b0;
    m_stopped      = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    check_outputs();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_target();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h0;
    if (r == 1) return 32'hBFC0_0000 | ($urandom & 32'h0000_FFFC) | $urandom_range(1, 3);
    if (r == 2) return 32'hFFFF_FFF4;
    return 32'hBFC0_0000 | ($urandom & 32'h0000_FFFC);
  endfunction

  initial begin
    reset           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    #1;
    do_reset(2);

    // Sequential run and taken branch with delay slot.
    repeat (4) step(1'b0, 1'b0, 32'h0);
    chk("pc_before_branch", instr_address, 32'hBFC0_0010);
    step(1'b0, 1'b1, 32'hBFC0_0100);
    chk("delay_slot_pc", if_pc, 32'hBFC0_0010);
    chk("branch_target", instr_address, 32'hBFC0_0100);

    // Stall holds a pending redirect, then it is accepted.
    step(1'b0, 1'b0, 32'h0);
    repeat (3) step(1'b1, 1'b1, 32'hBFC0_0200);
    step(1'b0, 1'b1, 32'hBFC0_0200);

    // Wrap of the PC past the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (3) step(1'b0, 1'b0, 32'h0);
    chk("pc_wrapped", instr_address, 32'h0000_0004);

    // Halt with delay slot, then ignored inputs for a while.
    step(1'b0, 1'b1, 32'hBFC0_0074);
    step(1'b0, 1'b1, 32'h0);
    chk("halt_delay_slot", if_pc, 32'hBFC0_0074);
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    repeat (12) step($urandom_range(0, 1), $urandom_range(0, 1), rand_target());

    // Misaligned redirect faults without a delay-slot capture.
    do_reset(1);
    repeat (2) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hBFC0_0102);
    repeat (3) step(1'b0, 1'b1, 32'hBFC0_0100);

    // Reset while halting.
    do_reset(1);
    step(1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    do_reset(1);
    step(1'b0, 1'b0, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (m_stopped && ($urandom_range(0, 3) == 0)) begin
        do_reset($urandom_range(1, 2));
      end else begin
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), rand_target());
      end
    end

    // Drain: halt and confirm every captured instruction was delivered.
    if (m_stopped) do_reset(1);
    step(1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 Parameter RESET_VECTOR, default 32'hBFC00000, is the first fetch address after reset.
REQ-002 Parameter HALT_ADDR, default 32'h00000000, is the redirect target that ends execution.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-low reset: sampled on clk, reset when 0.
REQ-005 Port stall  input  1  downstream hold; 1 freezes all fetch state.
REQ-006 Port redirect_valid  input  1  decode requests a control transfer; sampled only when stall=0.
REQ-007 Port redirect_target  input  32  byte address of the transfer target.
REQ-008 Port instr_address  output  32  byte address presented to instruction RAM, equal to the PC register.
REQ-009 Port instr_readdata  input  32  combinational instruction word returned for instr_address.
REQ-010 Port if_valid  output  1  if_instr/if_pc hold a live instruction for decode.
REQ-011 Port if_pc  output  32  byte address of if_instr.
REQ-012 Port if_instr  output  32  registered instruction word for decode.
REQ-013 Port active  output  1  core running; 0 once halted or faulted.
REQ-014 Port fetch_fault  output  1  sticky; set on misaligned redirect target.

Function
REQ-015 States SHALL be RUN, HALTING and HALTED; encoding is free.
REQ-016 instr_address SHALL be combinationally equal to the PC register in every state.
REQ-017 In RUN with stall=0, each cycle SHALL load if_instr<=instr_readdata, if_pc<=PC and if_valid<=1.
REQ-018 In RUN with stall=0 and redirect_valid=0, PC SHALL advance to PC+4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-019 In RUN with stall=0 and redirect_valid=1, PC SHALL load redirect_target; the word fetched in that cycle is the branch delay slot and SHALL be captured per REQ-017.
REQ-020 Redirect latency SHALL be one cycle: instr_address equals redirect_target in the cycle after acceptance.
REQ-021 With stall=1, PC, if_instr, if_pc, if_valid and state SHALL hold, and redirect_valid SHALL be ignored; decode holds the redirect until stall=0.
REQ-022 An accepted redirect with redirect_target==HALT_ADDR SHALL capture the delay slot and move RUN->HALTING; PC SHALL still load HALT_ADDR.
REQ-023 In HALTING with stall=0, the unit SHALL set if_valid<=0, move to HALTED and drive active=0 from the next cycle.
REQ-024 In HALTING with stall=1, the unit SHALL hold per REQ-021.
REQ-025 In HALTED, if_valid SHALL stay 0, PC SHALL hold, and stall/redirect SHALL be ignored until reset.
REQ-026 An accepted redirect with redirect_target[1:0]!=0 SHALL set fetch_fault=1 and if_valid<=0, and SHALL move directly to HALTED without capturing the delay slot.
REQ-027 Misalignment SHALL take priority over the HALT_ADDR check.
REQ-028 active SHALL be 1 in RUN and HALTING and 0 in HALTED.

Reset
REQ-029 While reset=0 at a clk edge: PC<=RESET_VECTOR, state<=RUN, if_valid<=0, if_pc<=0, if_instr<=0, fetch_fault<=0.
REQ-030 active SHALL read 1 from the first cycle after reset release.
REQ-031 Reset SHALL override stall and redirect in any state, including mid-HALTING.

Structure
REQ-032 The state enum, RESET_VECTOR and HALT_ADDR defaults and the instruction width constant SHALL live in a shared core package.
REQ-033 The block SHALL be a single module with no sub-modules; the instruction RAM is external.

Verification
REQ-034 Sequential run: release reset and hold stall=0 for 3 cycles -> instr_address is BFC00000, BFC00004, BFC00008; if_pc lags instr_address by one cycle; if_valid=1 from cycle 2.
REQ-035 Taken branch: redirect_valid=1 with target BFC00100 while PC=BFC00010 -> if_pc=BFC00010 (delay slot) on the next cycle, then instr_address=BFC00100.
REQ-036 Stall: assert stall for 3 cycles with redirect_valid=1 -> PC, if_instr and if_valid are frozen and the redirect is not taken; on release the redirect is accepted.
REQ-037 Halt: redirect target 0 at PC=BFC00074 -> delay slot BFC00074 is delivered valid, then if_valid=0 and active=0 one cycle later, and both stay so for 10+ cycles.
REQ-038 Fault: redirect target BFC00102 -> fetch_fault=1, active=0, no delay-slot capture.
REQ-039 Reset during HALTING -> next cycle PC=BFC00000, active=1, fetch_fault=0.
